// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
// The opcode encodings and chunk-width derivation are used by the top and its bench.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CW-bit adder chunk with carry out and carry into its MSB.
// c_msb lets the final chunk derive signed overflow without a second adder.
module adder_slice #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
  // Carry into the MSB is recovered from the MSB sum bit: s = x ^ y ^ c.
  assign c_msb   = x[CW-1] ^ y[CW-1] ^ s[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-chunked pipelined adder/subtractor with valid/ready flow control.
// Stage k adds chunk k; operands and partial sums ride along the pipeline.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = chunk_width(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CW{1'b1}});

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic              ovf_q;

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] ci;
  logic [STAGES-1:0] co;
  logic              cm    [STAGES];
  logic [CW-1:0]     x     [STAGES];
  logic [CW-1:0]     y     [STAGES];
  logic [CW-1:0]     s     [STAGES];
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_d   [STAGES];

  logic [WIDTH-1:0]  b_eff;
  logic              c0;

  // Subtraction is a + ~b + 1; cin only matters for addition.
  assign b_eff = (sub == OP_SUB) ? ~b : b;
  assign c0    = (sub == OP_SUB) ? 1'b1 : cin;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // A stage may load if any stage at or above it is empty, or the output drains.
      assign adv[gi] = out_ready | ~(&valid_q[STAGES-1:gi]);

      if (gi == 0) begin : g_first
        assign vin[gi]   = in_valid;
        assign a_src[gi] = a;
        assign b_src[gi] = b_eff;
        assign s_src[gi] = '0;
        assign ci[gi]    = c0;
      end else begin : g_rest
        assign vin[gi]   = valid_q[gi-1];
        assign a_src[gi] = a_q[gi-1];
        assign b_src[gi] = b_q[gi-1];
        assign s_src[gi] = s_q[gi-1];
        assign ci[gi]    = c_q[gi-1];
      end

      assign x[gi] = a_src[gi][gi*CW +: CW];
      assign y[gi] = b_src[gi][gi*CW +: CW];

      adder_slice #(.CW(CW)) u_slice (
        .x     (x[gi]),
        .y     (y[gi]),
        .ci    (ci[gi]),
        .s     (s[gi]),
        .co    (co[gi]),
        .c_msb (cm[gi])
      );

      assign s_d[gi] = (s_src[gi] & ~(CHUNK_MASK << (gi*CW))) |
                       (WIDTH'(s[gi]) << (gi*CW));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          valid_q[k] <= vin[k];
          if (vin[k]) begin
            a_q[k] <= a_src[k];
            b_q[k] <= b_src[k];
            s_q[k] <= s_d[k];
            c_q[k] <= co[k];
          end
        end
      end
      if (adv[STAGES-1] && vin[STAGES-1]) begin
        ovf_q <= cm[STAGES-1] ^ co[STAGES-1];
      end
    end
  end

  assign in_ready  = !rst && adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH % STAGES == 0; chunk width CW = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: operands present.
REQ-006 SHALL have port in_ready, output, 1: stage 0 can accept.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in; used only when sub=0.
REQ-010 SHALL have port sub, input, 1: 0 = a+b+cin; 1 = a-b.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port cout, output, 1: carry-out; for sub, 1 = no borrow.
REQ-015 SHALL have port ovf, output, 1: two's-complement signed overflow.

Function
REQ-016 SHALL accept an operation on a cycle where in_valid && in_ready are both high, and SHALL transfer a result on a cycle where out_valid && out_ready are both high.
REQ-017 SHALL compute sub=1 as a + ~b + 1, ignoring cin.
REQ-018 SHALL have stage k (0..STAGES-1) add chunk k (bits k*CW+CW-1 : k*CW) using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-019 SHALL delay unprocessed upper chunks and forward completed lower sum chunks alongside each stage, so that each result matches its own operands.
REQ-020 SHALL register the last stage as the output register; sum, cout and ovf SHALL be driven directly from it.
REQ-021 SHALL raise out_valid exactly STAGES cycles after acceptance when no stall occurs, giving a throughput of one operation per cycle.
REQ-022 SHALL compute ovf in the last stage as the carry into the MSB XOR the carry out of the MSB.
REQ-023 SHALL have a per-stage valid bit; stage k SHALL load when it is empty or when stage k+1 loads or drains, so bubbles collapse.
REQ-024 SHALL drive in_ready = !valid[0] || stage 1 loads; in_ready SHALL be combinational, with no dependency on in_valid.
REQ-025 SHALL hold sum, cout and ovf stable while out_valid && !out_ready.
REQ-026 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-027 SHALL support simultaneous accept and drain in one cycle when the pipeline is full; occupancy is unchanged.
REQ-028 SHALL reduce to a single registered adder with latency 1 when STAGES=1.

Reset
REQ-029 SHALL clear all valid bits on a cycle with rst high; out_valid SHALL read 0 the next cycle.
REQ-030 SHALL reset sum, cout and ovf to 0; data registers other than the output register are don't-care.
REQ-031 SHALL hold in_ready at 0 while rst is high and return it to 1 on the first cycle after release.
REQ-032 SHALL discard in-flight operations on reset mid-operation; no stale result SHALL appear after release.

Structure
REQ-033 SHALL place the opcode constants OP_ADD=0 and OP_SUB=1 and the CW derivation helper in shared package adder_pkg.
REQ-034 SHALL implement the combinational per-chunk adder as sub-module adder_slice (inputs CW-bit x, CW-bit y, ci; outputs CW-bit s, co, c_msb), instantiated STAGES times.

Verification (WIDTH=16, STAGES=4)
REQ-035 SHALL cover a basic carry across a chunk boundary: a=0x00FF, b=0x0001, cin=0, sub=0 -> sum=0x0100, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
REQ-036 SHALL cover full-width carry: a=0xFFFF, b=0x0001, cin=1 -> sum=0x0001, cout=1, ovf=0.
REQ-037 SHALL cover signed overflow in add and subtract:
- a=0x7FFF + b=0x0001 -> sum=0x8000, ovf=1, cout=0.
- a=0x8000 - b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-038 SHALL cover subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-039 SHALL cover backpressure: 8 back-to-back ops with out_ready held low 3 cycles after the first result -> in_ready drops once 4 are held, sum stays stable, all 8 results emerge in order.
REQ-040 SHALL cover reset mid-operation: rst pulsed with 3 ops in flight -> out_valid=0 and sum=0 next cycle, no result emerges, and a fresh op afterwards completes in 4 cycles.
